add8_sequencer: RTL and testbench

- Sequences the shared 4-bit cla_adder through two nibble passes (low, then high with carry chained) to perform 8-bit ADD/SUB for the 8-bit datapath.
- Sits between the control unit and the cla_adder instance. Owns the adder's en/A/B/c_in, consumes its ready/Output/c_out.
- Produces the 8-bit result, C/V/Z flags, a done pulse, and an error on adder timeout.

---
 rtl/add8_sequencer.sv | 163 ++++++++++++++++
 tb/tb_add8_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/add8_sequencer.sv
// 8-bit ADD/SUB built from two passes through a shared 4-bit carry-lookahead adder.
// The low nibble goes first, then the high nibble with the low carry chained in. Flags and an error are reported on a one-cycle done.
module add8_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_op_sub,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_result,
    output logic       o_flag_c,
    output logic       o_flag_v,
    output logic       o_flag_z,
    output logic       o_add_en,
    output logic [3:0] o_add_a,
    output logic [3:0] o_add_b,
    output logic       o_add_c_in,
    input  logic       i_add_ready,
    input  logic [3:0] i_add_sum,
    input  logic       i_add_c_out,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LO_REQ  = 3'd1,
        S_LO_WAIT = 3'd2,
        S_HI_REQ  = 3'd3,
        S_HI_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_L = TIMEOUT[7:0];

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_a;
    logic [7:0] r_bx;
    logic [3:0] r_lo;
    logic [7:0] r_wait_cnt;
    logic [7:0] r_result;
    logic       r_err;
    logic       r_flag_c;
    logic       r_flag_v;
    logic       r_flag_z;
    logic [3:0] r_add_a;
    logic [3:0] r_add_b;
    logic       r_add_c_in;
    logic [7:0] w_bx;
    logic       w_timeout;
    logic [7:0] w_sum8;

    assign w_bx      = i_op_sub ? ~i_b : i_b;
    assign w_timeout = (r_wait_cnt + 8'd1) == TIMEOUT_L;
    assign w_sum8    = {i_add_sum, r_lo};

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_next = S_LO_REQ;
            S_LO_REQ:  w_state_next = S_LO_WAIT;
            S_LO_WAIT: begin
                if (i_add_ready)    w_state_next = S_HI_REQ;
                else if (w_timeout) w_state_next = S_DONE;
            end
            S_HI_REQ:  w_state_next = S_HI_WAIT;
            S_HI_WAIT: begin
                if (i_add_ready || w_timeout) w_state_next = S_DONE;
            end
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Adder operands are registered on entry to each REQ state so they stay stable through the WAIT.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_a        <= 8'd0;
            r_bx       <= 8'd0;
            r_lo       <= 4'd0;
            r_wait_cnt <= 8'd0;
            r_result   <= 8'd0;
            r_err      <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_v   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_add_a    <= 4'd0;
            r_add_b    <= 4'd0;
            r_add_c_in <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a        <= i_a;
                        r_bx       <= w_bx;
                        r_add_a    <= i_a[3:0];
                        r_add_b    <= w_bx[3:0];
                        r_add_c_in <= i_op_sub;
                    end
                end
                S_LO_REQ, S_HI_REQ: r_wait_cnt <= 8'd0;
                S_LO_WAIT: begin
                    if (i_add_ready) begin
                        r_lo       <= i_add_sum;
                        r_add_a    <= r_a[7:4];
                        r_add_b    <= r_bx[7:4];
                        r_add_c_in <= i_add_c_out;
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= 8'd0;
                        r_flag_c <= 1'b0;
                        r_flag_v <= 1'b0;
                        r_flag_z <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_HI_WAIT: begin
                    if (i_add_ready) begin
                        r_err    <= 1'b0;
                        r_result <= w_sum8;
                        r_flag_c <= i_add_c_out;
                        r_flag_v <= (r_a[7] == r_bx[7]) && (i_add_sum[3] != r_a[7]);
                        r_flag_z <= (w_sum8 == 8'd0);
                    end else if (w_timeout) begin
                        r_err    <= 1'b1;
                        r_result <= 8'd0;
                        r_flag_c <= 1'b0;
                        r_flag_v <= 1'b0;
                        r_flag_z <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_add_en    = (r_state == S_LO_REQ) || (r_state == S_HI_REQ);
    assign o_err       = r_err;
    assign o_result    = r_result;
    assign o_flag_c    = r_flag_c;
    assign o_flag_v    = r_flag_v;
    assign o_flag_z    = r_flag_z;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_add_c_in  = r_add_c_in;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_add8_sequencer.sv
// Bench for add8_sequencer: behavioural 4-bit adder with programmable ready latency, 9-bit reference arithmetic,
// and a queue of expected {err,C,V,Z,result} words that is popped on each done.
module tb_add8_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op_sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy, done, err, flag_c, flag_v, flag_z;
    logic [7:0] result;
    logic       add_en, add_c_in;
    logic [3:0] add_a, add_b;
    logic       add_ready;
    logic [3:0] add_sum;
    logic       add_c_out;
    logic [2:0] dbg_state;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [11:0] exp_q[$];

    // adder model state
    int         m_lat   = 1;
    logic       m_never = 1'b0;
    int         m_cnt;
    logic [3:0] m_sum;
    logic       m_cout;

    always #5 clk = ~clk;

    add8_sequencer #(.TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_op_sub(op_sub),
        .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_err(err), .o_result(result),
        .o_flag_c(flag_c), .o_flag_v(flag_v), .o_flag_z(flag_z),
        .o_add_en(add_en), .o_add_a(add_a), .o_add_b(add_b), .o_add_c_in(add_c_in),
        .i_add_ready(add_ready), .i_add_sum(add_sum), .i_add_c_out(add_c_out),
        .o_dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0;
        end else if (add_en) begin
            m_cnt <= m_lat;
            {m_cout, m_sum} <= {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c_in};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end
    assign add_ready = (m_cnt == 1) && !m_never;
    assign add_sum   = m_sum;
    assign add_c_out = m_cout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_model(input logic [7:0] ra, input logic [7:0] rb, input logic sub);
        logic [8:0] s;
        logic [7:0] r;
        logic       v;
        s = {1'b0, ra} + (sub ? {1'b0, ~rb} : {1'b0, rb}) + {8'd0, sub};
        r = s[7:0];
        if (sub) v = (ra[7] != rb[7]) && (r[7] != ra[7]);
        else     v = (ra[7] == rb[7]) && (r[7] != ra[7]);
        return {1'b0, s[8], v, (r == 8'd0), r};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic sub,
                          input int lat, input logic never, input logic spam);
        int         cyc;
        int         en_n;
        int         en_c0, en_c1;
        logic       hi_cin;
        logic       seen;
        logic [11:0] e;
        logic [4:0] lo_sum;
        logic [7:0] bx;
        m_lat   = lat;
        m_never = never;
        bx      = sub ? ~tb : tb;
        lo_sum  = {1'b0, ta[3:0]} + {1'b0, bx[3:0]} + {4'd0, sub};
        exp_q.push_back(never ? 12'h800 : ref_model(ta, tb, sub));
        @(negedge clk);
        a = ta; b = tb; op_sub = sub; start = 1'b1;
        cyc = 0; en_n = 0; en_c0 = -1; en_c1 = -1; hi_cin = 1'b0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = spam;
            if (spam) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                op_sub = 1'($urandom_range(0, 1));
            end
            if (add_en) begin
                if (en_n == 0) en_c0 = cyc;
                if (en_n == 1) begin en_c1 = cyc; hi_cin = add_c_in; end
                en_n++;
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("done_cycle", 32'(cyc), never ? 32'd17 : 32'(3 + 2 * lat));
            e = exp_q.pop_front();
            chk("result", 32'(result), 32'(e[7:0]));
            chk("flag_z", 32'(flag_z), 32'(e[8]));
            chk("flag_v", 32'(flag_v), 32'(e[9]));
            chk("flag_c", 32'(flag_c), 32'(e[10]));
            chk("err",    32'(err),    32'(e[11]));
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("en_count", 32'(en_n), never ? 32'd1 : 32'd2);
            chk("en_lo_cycle", 32'(en_c0), 32'd1);
            if (!never) begin
                chk("en_hi_cycle", 32'(en_c1), 32'(2 + lat));
                chk("hi_c_in", 32'(hi_cin), 32'(lo_sum[4]));
            end
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_add_en", 32'(add_en), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_v, flag_z}), 32'd0);
        chk("rst_add_ops", 32'({add_a, add_b, add_c_in}), 32'd0);
        reset = 1'b0;

        run_op(8'h12, 8'h34, 1'b0, 1, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 3, 1'b0, 1'b1);
        run_op(8'hA5, 8'h3C, 1'b0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)));
        end

        // abort in HI_WAIT: L=3 puts HI_REQ at cycle 5, HI_WAIT at cycle 6
        m_lat = 3; m_never = 1'b0;
        @(negedge clk);
        a = 8'h55; b = 8'h22; op_sub = 1'b0; start = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_add_en", 32'(add_en), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'h01, 8'h02, 1'b0, 1, 1'b0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
